line_mem_arbiter: RTL and testbench
===================================

# line_mem_arbiter

Shares the single 128-bit-line backing RAM between the Icache refill port (read only) and the Dcache port (line read and dirty-line writeback). Sits between both caches and the line RAM. Serialises requests with round-robin arbitration and keeps a Dcache writeback+refill pair atomic. Isolates each cache from the RAM's registered ready, which lasts more than one cycle. Adds a watchdog against a RAM that never answers.

## Interface
- TIMEOUT, 64: cycles a RAM request may stay unanswered before it is aborted (range 2..255).
- clk  in  1  single clock; all flops on rising edge.
- rst  in  1  asynchronous reset, active-high.
- Icache_rd_req_i  in  1  Icache line-read request, level, held until Icache_ready_o.
- Icache_rd_addr_i  in  32  Icache line address.
- Icache_data_o  out  128  returned Icache line.
- Icache_ready_o  out  1  one-cycle completion pulse to Icache.
- Dcache_rd_req_i  in  1  Dcache line-read request, level.
- Dcache_rd_addr_i  in  32  Dcache read address.
- Dcache_wb_req_i  in  1  Dcache writeback request, level; may be high together with Dcache_rd_req_i.
- Dcache_wb_addr_i  in  32  writeback address.
- Dcache_data_ram_i  in  128  writeback line.
- Dcache_data_o  out  128  returned Dcache line.
- Dcache_ready_o  out  1  one-cycle completion pulse to Dcache.
- ram_rd_req_o / ram_rd_addr_o  out  1/32  RAM read request and address.
- ram_wb_req_o / ram_wb_addr_o / ram_wb_data_o  out  1/32/128  RAM writeback request, address and line.
- ram_data_i  in  128  RAM read line, valid while ram_ready_i=1.
- ram_ready_i  in  1  RAM completion, registered; stays high while a request is held.
- busy_o  out  1  arbiter not in IDLE.
- timeout_err_o  out  1  sticky: a RAM request timed out.

## Operation
- All outputs are registered. Every address is sent to the RAM with bits [3:0] forced to 0 (16-byte line alignment).
- The FSM has five states: IDLE, WB, RD, DRAIN and RESP. A 1-bit `owner` register records the current requester, a 1-bit `last` register records the previous one, and a `pend_rd` flag records a read still to run.
- IDLE: a request from a cache is eligible when its req is high and that cache is not masked.
  - If both caches are eligible, the one not equal to `last` wins. On reset `last`=Icache, so Dcache wins the first tie.
  - An Icache grant goes to RD.
  - A Dcache grant goes to WB when wb_req=1, with pend_rd set to rd_req. Otherwise it goes to RD.
  - At grant, the address and writeback data are latched into the RAM-side output registers.
- WB: ram_wb_req_o=1. When ram_ready_i=1, go to DRAIN.
- RD: ram_rd_req_o=1. When ram_ready_i=1, capture ram_data_i into the owner's data_o register, then go to DRAIN.
- DRAIN: all RAM requests are 0. Wait until ram_ready_i=0.
  - If pend_rd=1, clear pend_rd, latch the Dcache read address, and go to RD. No arbitration happens here, so the pair stays atomic.
  - Otherwise go to RESP.
- RESP: pulse the owner's ready_o for one cycle, set `last`=owner, go to IDLE. In that IDLE cycle the owner is masked, because its req may still be high for one cycle.
- Dcache_ready_o pulses exactly once per Dcache transaction, including a writeback+read pair.
- Watchdog: an 8-bit counter is cleared on entry to WB/RD and increments every cycle in WB/RD while ram_ready_i=0. When it reaches TIMEOUT:
  - drop the RAM request;
  - set timeout_err_o;
  - clear pend_rd;
  - load zero into the owner's data_o;
  - go to DRAIN.
- Icache_data_o and Dcache_data_o hold their last value until the next capture for that cache.
- rst at any time returns the block to IDLE and clears all outputs; any in-flight RAM operation is abandoned.
- Reset values: every output is 0; `last`=Icache; pend_rd=0; counter=0.

## Timing
- RAM model: ram_ready_i rises one cycle after a request is first sampled, and falls one cycle after the request is removed.
- Lone Icache read, req first sampled at edge 0:
  - RD in cycle 1;
  - ram_ready_i in cycle 2, data captured at the end of cycle 2;
  - DRAIN in cycles 3-4;
  - Icache_ready_o=1 in cycle 5.
- Lone Dcache writeback, or lone Dcache read: 5 cycles, same profile.
- Dcache writeback+read pair: WB in cycle 1, RD in cycle 5, Dcache_ready_o in cycle 9.
- A RAM request is never reissued until ram_ready_i has been sampled low.
- The next grant can start no earlier than the cycle after RESP+1.
- A cache that drops its req before its ready pulse still receives that pulse; requesters must not do this.

## Test plan
- Reset check: assert rst mid-cycle, asynchronously -> all outputs are 0 immediately. Release rst, then assert Icache_rd_req_i with address 0x104 -> ram_rd_addr_o=0x100, and Icache_ready_o pulses in cycle 5 with the 128-bit RAM line.
- Simultaneous start: Icache read at 0x000 and Dcache read at 0x200 both go high at edge 0 -> Dcache is served first (ready in cycle 5). Icache is served next (ready in cycle 11). There is exactly one ready pulse each.
- Round-robin: both requesters re-request continuously -> grants alternate D, I, D, I, and neither starves.
- Atomic eviction: Dcache wb (0x300, data 0xAA..AA) and Dcache rd (0x400) are issued together while Icache requests -> RAM sees the wb, then the rd, with no Icache operation between them. Dcache_ready_o pulses once, in cycle 9. A later read of 0x300 returns 0xAA..AA.
- Watchdog: TIMEOUT=4, RAM model holds ram_ready_i at 0 -> ram_rd_req_o drops after 4 cycles. timeout_err_o=1 and stays 1. The requester receives a ready pulse with data 0.
- Reset mid-transaction: rst is asserted while in WB -> ram_wb_req_o=0 and busy_o=0 immediately. After release, a new Icache request completes normally.

Source files
------------

// File: rtl/line_mem_arbiter_if.sv
// Cache-side and RAM-side signal bundle of the line memory arbiter.
// slave: the arbiter's view; master: the caches plus the RAM driving it.
interface line_mem_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 128;

    logic              Icache_rd_req_i;
    logic [ADDR_W-1:0] Icache_rd_addr_i;
    logic [LINE_W-1:0] Icache_data_o;
    logic              Icache_ready_o;

    logic              Dcache_rd_req_i;
    logic [ADDR_W-1:0] Dcache_rd_addr_i;
    logic              Dcache_wb_req_i;
    logic [ADDR_W-1:0] Dcache_wb_addr_i;
    logic [LINE_W-1:0] Dcache_data_ram_i;
    logic [LINE_W-1:0] Dcache_data_o;
    logic              Dcache_ready_o;

    logic              ram_rd_req_o;
    logic [ADDR_W-1:0] ram_rd_addr_o;
    logic              ram_wb_req_o;
    logic [ADDR_W-1:0] ram_wb_addr_o;
    logic [LINE_W-1:0] ram_wb_data_o;
    logic [LINE_W-1:0] ram_data_i;
    logic              ram_ready_i;

    logic              busy_o;
    logic              timeout_err_o;

    modport slave (
        input  Icache_rd_req_i, Icache_rd_addr_i,
        output Icache_data_o, Icache_ready_o,
        input  Dcache_rd_req_i, Dcache_rd_addr_i, Dcache_wb_req_i,
        input  Dcache_wb_addr_i, Dcache_data_ram_i,
        output Dcache_data_o, Dcache_ready_o,
        output ram_rd_req_o, ram_rd_addr_o, ram_wb_req_o, ram_wb_addr_o, ram_wb_data_o,
        input  ram_data_i, ram_ready_i,
        output busy_o, timeout_err_o
    );

    modport master (
        output Icache_rd_req_i, Icache_rd_addr_i,
        input  Icache_data_o, Icache_ready_o,
        output Dcache_rd_req_i, Dcache_rd_addr_i, Dcache_wb_req_i,
        output Dcache_wb_addr_i, Dcache_data_ram_i,
        input  Dcache_data_o, Dcache_ready_o,
        input  ram_rd_req_o, ram_rd_addr_o, ram_wb_req_o, ram_wb_addr_o, ram_wb_data_o,
        output ram_data_i, ram_ready_i,
        input  busy_o, timeout_err_o
    );
endinterface

// File: rtl/line_mem_arbiter.sv
// Round-robin arbiter sharing one line RAM between Icache refills and Dcache
// reads/writebacks; writeback+read pairs are atomic, with a RAM watchdog.
module line_mem_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input logic               clk,
    input logic               rst,
    line_mem_arbiter_if.slave bus
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned CNT_W  = 8;
    localparam logic        OWN_I  = 1'b0;
    localparam logic        OWN_D  = 1'b1;

    typedef enum logic [2:0] {IDLE, WB, RD, DRAIN, RESP} state_t;

    state_t           state;
    logic             owner;
    logic             last;
    logic             pend_rd;
    logic             mask_last;
    logic [CNT_W-1:0] wd_cnt;

    logic i_elig;
    logic d_elig;
    logic grant_d;
    logic wd_expire;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(32'hF);
    endfunction

    // Eligibility and tie-break; the previous owner is masked for one IDLE cycle after RESP.
    always_comb begin
        i_elig    = bus.Icache_rd_req_i && !(mask_last && (last == OWN_I));
        d_elig    = (bus.Dcache_rd_req_i || bus.Dcache_wb_req_i) && !(mask_last && (last == OWN_D));
        grant_d   = d_elig && (!i_elig || (last == OWN_I));
        wd_expire = ((CNT_W + 1)'(wd_cnt) + (CNT_W + 1)'(1)) >= (CNT_W + 1)'(TIMEOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            owner             <= OWN_I;
            last              <= OWN_I;
            pend_rd           <= 1'b0;
            mask_last         <= 1'b0;
            wd_cnt            <= '0;
            bus.Icache_data_o <= '0;
            bus.Icache_ready_o <= 1'b0;
            bus.Dcache_data_o <= '0;
            bus.Dcache_ready_o <= 1'b0;
            bus.ram_rd_req_o  <= 1'b0;
            bus.ram_rd_addr_o <= '0;
            bus.ram_wb_req_o  <= 1'b0;
            bus.ram_wb_addr_o <= '0;
            bus.ram_wb_data_o <= '0;
            bus.busy_o        <= 1'b0;
            bus.timeout_err_o <= 1'b0;
        end else begin
            bus.Icache_ready_o <= 1'b0;
            bus.Dcache_ready_o <= 1'b0;

            case (state)
                IDLE: begin
                    mask_last <= 1'b0;
                    if (i_elig || d_elig) begin
                        wd_cnt     <= '0;
                        bus.busy_o <= 1'b1;
                        if (grant_d) begin
                            owner <= OWN_D;
                            if (bus.Dcache_wb_req_i) begin
                                state             <= WB;
                                pend_rd           <= bus.Dcache_rd_req_i;
                                bus.ram_wb_req_o  <= 1'b1;
                                bus.ram_wb_addr_o <= line_align(bus.Dcache_wb_addr_i);
                                bus.ram_wb_data_o <= bus.Dcache_data_ram_i;
                            end else begin
                                state             <= RD;
                                bus.ram_rd_req_o  <= 1'b1;
                                bus.ram_rd_addr_o <= line_align(bus.Dcache_rd_addr_i);
                            end
                        end else begin
                            owner             <= OWN_I;
                            state             <= RD;
                            bus.ram_rd_req_o  <= 1'b1;
                            bus.ram_rd_addr_o <= line_align(bus.Icache_rd_addr_i);
                        end
                    end
                end

                WB: begin
                    if (bus.ram_ready_i) begin
                        bus.ram_wb_req_o <= 1'b0;
                        state            <= DRAIN;
                    end else if (wd_expire) begin
                        bus.ram_wb_req_o  <= 1'b0;
                        bus.timeout_err_o <= 1'b1;
                        pend_rd           <= 1'b0;
                        bus.Dcache_data_o <= '0;
                        state             <= DRAIN;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end

                RD: begin
                    if (bus.ram_ready_i) begin
                        bus.ram_rd_req_o <= 1'b0;
                        if (owner == OWN_D) bus.Dcache_data_o <= bus.ram_data_i;
                        else                bus.Icache_data_o <= bus.ram_data_i;
                        state <= DRAIN;
                    end else if (wd_expire) begin
                        bus.ram_rd_req_o  <= 1'b0;
                        bus.timeout_err_o <= 1'b1;
                        pend_rd           <= 1'b0;
                        if (owner == OWN_D) bus.Dcache_data_o <= '0;
                        else                bus.Icache_data_o <= '0;
                        state <= DRAIN;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end

                // Wait for the RAM's ready to fall; the pending read of a pair skips arbitration.
                DRAIN: begin
                    if (!bus.ram_ready_i) begin
                        if (pend_rd) begin
                            pend_rd           <= 1'b0;
                            wd_cnt            <= '0;
                            bus.ram_rd_req_o  <= 1'b1;
                            bus.ram_rd_addr_o <= line_align(bus.Dcache_rd_addr_i);
                            state             <= RD;
                        end else begin
                            if (owner == OWN_D) bus.Dcache_ready_o <= 1'b1;
                            else                bus.Icache_ready_o <= 1'b1;
                            state <= RESP;
                        end
                    end
                end

                RESP: begin
                    last       <= owner;
                    mask_last  <= 1'b1;
                    bus.busy_o <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state            <= IDLE;
                    bus.busy_o       <= 1'b0;
                    bus.ram_rd_req_o <= 1'b0;
                    bus.ram_wb_req_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_line_mem_arbiter.sv
// Randomized bench for line_mem_arbiter: transaction-level reference model with
// a line memory, serve order and spec-derived completion cycles.
module tb_line_mem_arbiter;
    typedef struct packed {
        logic        wb;
        logic [31:0] addr;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    line_mem_arbiter_if bus();
    line_mem_arbiter #(.TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] ram_mem [logic [27:0]];
    logic [127:0] m_mem   [logic [27:0]];
    op_t          op_log[$];
    bit           stall;
    bit           last_d;
    logic [127:0] m_i_data;
    logic [127:0] m_d_data;

    function automatic logic [127:0] init_line(input logic [27:0] idx);
        logic [31:0] x;
        x = {4'h0, idx};
        return {x * 32'h9E3779B1, x ^ 32'hC3A55A3C, ~x, x + 32'h01010101};
    endfunction

    function automatic logic [127:0] ram_line(input logic [27:0] idx);
        return ram_mem.exists(idx) ? ram_mem[idx] : init_line(idx);
    endfunction

    function automatic logic [127:0] m_line(input logic [27:0] idx);
        return m_mem.exists(idx) ? m_mem[idx] : init_line(idx);
    endfunction

    function automatic logic [31:0] rand_addr();
        return (32'($urandom_range(0, 31)) << 4) | 32'($urandom_range(0, 15));
    endfunction

    // RAM: ready one cycle after a request is sampled, drops one cycle after it goes away.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ram_ready_i <= 1'b0;
            bus.ram_data_i  <= '0;
        end else if ((bus.ram_rd_req_o || bus.ram_wb_req_o) && !stall) begin
            if (!bus.ram_ready_i) begin
                if (bus.ram_wb_req_o) begin
                    ram_mem[bus.ram_wb_addr_o[31:4]] = bus.ram_wb_data_o;
                    op_log.push_back(op_t'({1'b1, bus.ram_wb_addr_o}));
                end
                if (bus.ram_rd_req_o) begin
                    bus.ram_data_i <= ram_line(bus.ram_rd_addr_o[31:4]);
                    op_log.push_back(op_t'({1'b0, bus.ram_rd_addr_o}));
                end
            end
            bus.ram_ready_i <= 1'b1;
        end else begin
            bus.ram_ready_i <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        bus.Icache_rd_req_i = 1'b0;
        bus.Dcache_rd_req_i = 1'b0;
        bus.Dcache_wb_req_i = 1'b0;
    endtask

    // Fire rst mid-cycle, confirm outputs clear at once, then release and resync the model.
    task automatic async_reset_check();
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy", bus.busy_o, 0);
        check("rst_rd_req", bus.ram_rd_req_o, 0);
        check("rst_wb_req", bus.ram_wb_req_o, 0);
        check("rst_rd_addr", bus.ram_rd_addr_o, 0);
        check("rst_wb_data", bus.ram_wb_data_o, 0);
        check("rst_i_data", bus.Icache_data_o, 0);
        check("rst_d_data", bus.Dcache_data_o, 0);
        check("rst_err", bus.timeout_err_o, 0);
        drop_reqs();
        #3;
        rst = 1'b0;
        tick();
        op_log.delete();
        last_d   = 1'b0;
        m_i_data = '0;
        m_d_data = '0;
    endtask

    task automatic run_round(input bit ir, input logic [31:0] ia, input bit dr,
                             input logic [31:0] dra, input bit dw,
                             input logic [31:0] dwa, input logic [127:0] dwd);
        bit           d_act, d_first, serve_d;
        int           t_done, lat, exp_i_cyc, exp_d_cyc, got_i_cyc, got_d_cyc, n_i, n_d;
        logic [127:0] exp_i, exp_d, got_i, got_d;
        op_t          exp_ops[$];
        d_act   = dr || dw;
        d_first = d_act && (!ir || !last_d);
        t_done  = 0;
        exp_i_cyc = 0; exp_d_cyc = 0; got_i_cyc = 0; got_d_cyc = 0; n_i = 0; n_d = 0;
        exp_i = m_i_data; exp_d = m_d_data; got_i = '0; got_d = '0;
        for (int k = 0; k < 2; k++) begin
            serve_d = (k == 0) ? d_first : !d_first;
            if (serve_d ? !d_act : !ir) continue;
            if (serve_d) begin
                if (dw) begin
                    m_mem[dwa[31:4]] = dwd;
                    exp_ops.push_back(op_t'({1'b1, dwa[31:4], 4'h0}));
                end
                if (dr) begin
                    exp_d = m_line(dra[31:4]);
                    exp_ops.push_back(op_t'({1'b0, dra[31:4], 4'h0}));
                end
                lat = (dw && dr) ? 9 : 5;
            end else begin
                exp_i = m_line(ia[31:4]);
                exp_ops.push_back(op_t'({1'b0, ia[31:4], 4'h0}));
                lat = 5;
            end
            t_done = (t_done == 0) ? lat : t_done + 1 + lat;
            if (serve_d) exp_d_cyc = t_done;
            else         exp_i_cyc = t_done;
            last_d = serve_d;
        end

        bus.Icache_rd_req_i   = ir;
        bus.Icache_rd_addr_i  = ia;
        bus.Dcache_rd_req_i   = dr;
        bus.Dcache_rd_addr_i  = dra;
        bus.Dcache_wb_req_i   = dw;
        bus.Dcache_wb_addr_i  = dwa;
        bus.Dcache_data_ram_i = dwd;
        for (int t = 1; t <= 22; t++) begin
            tick();
            if (bus.Icache_ready_o) begin
                n_i++; got_i_cyc = t; got_i = bus.Icache_data_o;
                bus.Icache_rd_req_i = 1'b0;
            end
            if (bus.Dcache_ready_o) begin
                n_d++; got_d_cyc = t; got_d = bus.Dcache_data_o;
                bus.Dcache_rd_req_i = 1'b0;
                bus.Dcache_wb_req_i = 1'b0;
            end
        end

        check("i_pulses", n_i, ir);
        check("d_pulses", n_d, d_act);
        if (ir) begin
            check("i_ready_cycle", got_i_cyc, exp_i_cyc);
            check("i_data", got_i, exp_i);
        end
        if (d_act) begin
            check("d_ready_cycle", got_d_cyc, exp_d_cyc);
            check("d_data", got_d, exp_d);
        end
        check("ram_op_count", op_log.size(), exp_ops.size());
        for (int i = 0; i < op_log.size() && i < exp_ops.size(); i++)
            check("ram_op", op_log[i], exp_ops[i]);
        check("end_busy", bus.busy_o, 0);
        check("no_timeout", bus.timeout_err_o, 0);
        op_log.delete();
        m_i_data = exp_i;
        m_d_data = exp_d;
    endtask

    // Both caches keep requesting; completions must alternate.
    task automatic run_rr();
        bit          exp_d;
        int          pulses;
        logic [31:0] ia, da;
        exp_d  = !last_d;
        pulses = 0;
        ia = rand_addr();
        da = rand_addr();
        bus.Icache_rd_addr_i = ia;
        bus.Dcache_rd_addr_i = da;
        bus.Icache_rd_req_i  = 1'b1;
        bus.Dcache_rd_req_i  = 1'b1;
        bus.Dcache_wb_req_i  = 1'b0;
        for (int t = 0; t < 150 && pulses < 8; t++) begin
            tick();
            if (bus.Icache_ready_o || bus.Dcache_ready_o) begin
                check("rr_owner", bus.Dcache_ready_o, exp_d);
                if (bus.Dcache_ready_o) begin
                    m_d_data = m_line(da[31:4]);
                    check("rr_d_data", bus.Dcache_data_o, m_d_data);
                    da = rand_addr();
                    bus.Dcache_rd_addr_i = da;
                end else begin
                    m_i_data = m_line(ia[31:4]);
                    check("rr_i_data", bus.Icache_data_o, m_i_data);
                    ia = rand_addr();
                    bus.Icache_rd_addr_i = ia;
                end
                last_d = exp_d;
                exp_d  = !exp_d;
                pulses++;
            end
        end
        check("rr_pulses", pulses, 8);
        drop_reqs();
        repeat (4) tick();
        op_log.delete();
    endtask

    initial begin
        int           got_cyc, n_p;
        logic [127:0] got_data;
        int           dk;
        rst = 1'b1;
        stall = 1'b0;
        drop_reqs();
        bus.Icache_rd_addr_i  = '0;
        bus.Dcache_rd_addr_i  = '0;
        bus.Dcache_wb_addr_i  = '0;
        bus.Dcache_data_ram_i = '0;
        last_d = 1'b0;
        m_i_data = '0;
        m_d_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("por_busy", bus.busy_o, 0);
        check("por_ready", {bus.Icache_ready_o, bus.Dcache_ready_o}, 0);
        rst = 1'b0;
        tick();

        // Lone Icache read with unaligned address.
        run_round(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 128'h0);

        // Reset during an Icache read.
        bus.Icache_rd_addr_i = 32'h2F0;
        bus.Icache_rd_req_i  = 1'b1;
        tick();
        tick();
        check("rd_in_flight", bus.ram_rd_req_o, 1);
        async_reset_check();

        // Reset while in WB, then a normal Icache read.
        bus.Dcache_wb_addr_i  = 32'h500;
        bus.Dcache_data_ram_i = {4{$urandom}};
        bus.Dcache_wb_req_i   = 1'b1;
        tick();
        check("wb_in_flight", bus.ram_wb_req_o, 1);
        async_reset_check();
        run_round(1'b1, rand_addr(), 1'b0, 32'h0, 1'b0, 32'h0, 128'h0);

        // Simultaneous start, then atomic eviction and read-back.
        run_round(1'b1, 32'h000, 1'b1, 32'h200, 1'b0, 32'h0, 128'h0);
        run_round(1'b1, rand_addr(), 1'b1, 32'h400, 1'b1, 32'h300, {32{4'hA}});
        run_round(1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 32'h0, 128'h0);

        run_rr();

        repeat (40) begin
            dk = int'($urandom_range(0, 3));
            run_round(1'($urandom_range(0, 1)), rand_addr(), dk[0], rand_addr(),
                      dk[1], rand_addr(), {$urandom, $urandom, $urandom, $urandom});
        end

        // Watchdog: RAM never answers.
        stall = 1'b1;
        got_cyc = 0;
        n_p = 0;
        got_data = '1;
        bus.Icache_rd_addr_i = 32'h7A0;
        bus.Icache_rd_req_i  = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 4) check("wd_req_held", bus.ram_rd_req_o, 1);
            if (t == 5) begin
                check("wd_req_drop", bus.ram_rd_req_o, 0);
                check("wd_err_set", bus.timeout_err_o, 1);
            end
            if (bus.Icache_ready_o) begin
                n_p++; got_cyc = t; got_data = bus.Icache_data_o;
                bus.Icache_rd_req_i = 1'b0;
            end
        end
        check("wd_pulses", n_p, 1);
        check("wd_ready_cycle", got_cyc, 6);
        check("wd_data", got_data, 0);
        check("wd_err_sticky", bus.timeout_err_o, 1);
        stall = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
